// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of ro_in
// over a programmable window of clk cycles and publishes the count with a
// valid/ack handshake.
module ro_freq_meter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned GATE_W      = 16,
   parameter int unsigned CNT_W       = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ro_in,
   input  logic              start,
   input  logic [GATE_W-1:0] gate_len,
   output logic              busy,
   output logic [CNT_W-1:0]  result,
   output logic              result_valid,
   input  logic              result_ack,
   output logic              overflow
);

   // Fewer than two stages would not resolve metastability.
   localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   typedef enum logic [1:0] {StIdle, StArm, StCount, StDone} state_e;

   state_e            state_q, state_d;
   logic [SS-1:0]     sync_q;
   logic              hist_q;
   logic              rise;
   logic [GATE_W-1:0] gate_q, gate_d;
   logic [CNT_W-1:0]  edge_q, edge_d;
   logic              flag_q, flag_d;
   logic [CNT_W-1:0]  result_q, result_d;
   logic              ovf_q, ovf_d;
   logic              valid_q, valid_d;
   logic              publish;

   // Synchronizer chain plus history flop; runs continuously in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SS-2:0], ro_in};
         hist_q <= sync_q[SS-1];
      end
   end

   assign rise = sync_q[SS-1] & ~hist_q;

   // State, window counters and published result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         gate_q   <= '0;
         edge_q   <= '0;
         flag_q   <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         gate_q   <= gate_d;
         edge_q   <= edge_d;
         flag_q   <= flag_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
      end
   end

   // Next-state logic: window sequencing, saturating edge count, handshake.
   always_comb begin
      state_d  = state_q;
      gate_d   = gate_q;
      edge_d   = edge_q;
      flag_d   = flag_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      valid_d  = valid_q;
      publish  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               gate_d  = gate_len;
               edge_d  = '0;
               flag_d  = 1'b0;
               state_d = StArm;
            end
         end
         StArm: begin
            // Rises seen here are not counted; the history flop keeps tracking.
            if (gate_q != '0) begin
               state_d = StCount;
            end else begin
               state_d = StDone;
               publish = 1'b1;
            end
         end
         StCount: begin
            if (rise) begin
               if (&edge_q) begin
                  flag_d = 1'b1;
               end else begin
                  edge_d = edge_q + CNT_W'(1);
               end
            end
            gate_d = gate_q - GATE_W'(1);
            // Last window cycle: its rise is already folded into edge_d.
            if (gate_q == GATE_W'(1)) begin
               state_d = StDone;
               publish = 1'b1;
            end
         end
         StDone: begin
            if (result_ack && valid_q) begin
               valid_d = 1'b0;
               if (start) begin
                  gate_d  = gate_len;
                  edge_d  = '0;
                  flag_d  = 1'b0;
                  state_d = StArm;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (publish) begin
         result_d = edge_d;
         ovf_d    = flag_d;
         valid_d  = 1'b1;
      end
   end

   assign busy         = (state_q != StIdle);
   assign result       = result_q;
   assign overflow     = ovf_q;
   assign result_valid = valid_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: a wide (default) and a narrow (CNT_W=4) instance
// share stimulus and are checked every cycle against a window-level model.
module tb_ro_freq_meter;

   localparam int S  = 2;
   localparam int CN = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ro_in = 1'b0;
   logic        start = 1'b0;
   logic        result_ack = 1'b0;
   logic [15:0] gate_len = '0;

   logic        busy_w, valid_w, ovf_w;
   logic [23:0] res_w;
   logic        busy_n, valid_n, ovf_n;
   logic [3:0]  res_n;

   ro_freq_meter u_wide (
      .clk          (clk),
      .rst_n        (rst_n),
      .ro_in        (ro_in),
      .start        (start),
      .gate_len     (gate_len),
      .busy         (busy_w),
      .result       (res_w),
      .result_valid (valid_w),
      .result_ack   (result_ack),
      .overflow     (ovf_w)
   );

   ro_freq_meter #(.CNT_W(CN)) u_narrow (
      .clk          (clk),
      .rst_n        (rst_n),
      .ro_in        (ro_in),
      .start        (start),
      .gate_len     (gate_len),
      .busy         (busy_n),
      .result       (res_n),
      .result_valid (valid_n),
      .result_ack   (result_ack),
      .overflow     (ovf_n)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ro_in generator: 0 = hold, 1 = clock-aligned periodic, 2 = random phase/rate.
   int ro_mode = 0;
   int ro_per  = 10;
   int ro_rate = 50;
   int ro_phase = 0;
   int last_per = 0;
   always @(negedge clk) begin
      if (ro_mode == 1) begin
         #1;
         if (ro_per != last_per) begin
            ro_phase = 0;
            last_per = ro_per;
         end
         ro_in = (ro_phase < ro_per / 2);
         ro_phase = (ro_phase + 1) % ro_per;
      end else if (ro_mode == 2) begin
         #($urandom_range(1, 4));
         if ($urandom_range(0, 99) < ro_rate) ro_in = ~ro_in;
      end
   end

   // Reference model: per-edge record of what the first sync flop captures,
   // and a window timeline (start edge, length, publish edge).
   bit     samp[$];
   longint cyc = -1;
   bit     m_busy = 0, m_valid = 0, m_ovf_w = 0, m_ovf_n = 0;
   longint m_s = 0, m_len = 0, m_done = 0, m_res_w = 0, m_res_n = 0;

   function automatic bit sv(longint i);
      return (i < 0) ? 1'b0 : samp[i];
   endfunction

   // Rise in the cycle after edge k: synchronized value rose from edge k-1 to k.
   function automatic longint count_rises(longint s, longint len);
      longint c = 0;
      for (longint k = s + 1; k <= s + len; k++) begin
         if (sv(k - S + 1) && !sv(k - S)) c++;
      end
      return c;
   endfunction

   always @(posedge clk) begin
      longint t;
      cyc++;
      samp.push_back(rst_n ? ro_in : 1'b0);
      if (!rst_n) begin
         m_busy = 0; m_valid = 0; m_res_w = 0; m_res_n = 0; m_ovf_w = 0; m_ovf_n = 0;
      end else begin
         if (m_valid && result_ack) begin
            m_valid = 0;
            if (start) begin
               m_s = cyc; m_len = longint'(gate_len); m_done = cyc + m_len + 1;
            end else begin
               m_busy = 0;
            end
         end else if (!m_busy && start) begin
            m_busy = 1; m_s = cyc; m_len = longint'(gate_len); m_done = cyc + m_len + 1;
         end
         if (m_busy && !m_valid && cyc == m_done) begin
            t = count_rises(m_s, m_len);
            m_res_w = (t > 64'hFF_FFFF) ? 64'hFF_FFFF : t;
            m_ovf_w = (t > 64'hFF_FFFF);
            m_res_n = (t > 15) ? 15 : t;
            m_ovf_n = (t > 15);
            m_valid = 1;
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      chk("busy_w", longint'(busy_w), longint'(m_busy));
      chk("valid_w", longint'(valid_w), longint'(m_valid));
      chk("result_w", longint'(res_w), m_res_w);
      chk("ovf_w", longint'(ovf_w), longint'(m_ovf_w));
      chk("busy_n", longint'(busy_n), longint'(m_busy));
      chk("valid_n", longint'(valid_n), longint'(m_valid));
      chk("result_n", longint'(res_n), m_res_n);
      chk("ovf_n", longint'(ovf_n), longint'(m_ovf_n));
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Start sampled at the next edge; returns in cycle 1 (ARM).
   task automatic go(input int len);
      start = 1'b1;
      gate_len = 16'(len);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic ack();
      result_ack = 1'b1;
      @(negedge clk);
      result_ack = 1'b0;
   endtask

   task automatic ack_start(input int len);
      result_ack = 1'b1;
      start = 1'b1;
      gate_len = 16'(len);
      @(negedge clk);
      result_ack = 1'b0;
      start = 1'b0;
   endtask

   // Wait for result_valid with a cycle budget, throwing ignored start/ack pulses.
   task automatic wait_valid(input int budget);
      for (int i = 0; i < budget && !valid_w; i++) begin
         start = ($urandom_range(0, 7) == 0);
         gate_len = 16'($urandom);
         result_ack = ($urandom_range(0, 7) == 0);
         @(negedge clk);
      end
      start = 1'b0;
      result_ack = 1'b0;
      chk("wait_valid", longint'(valid_w), 1);
   endtask

   function automatic int pick_len();
      int r = $urandom_range(0, 9);
      if (r == 0) return 0;
      if (r == 1) return 1;
      return $urandom_range(2, 200);
   endfunction

   initial begin
      longint stop_at;
      int len;
      cycles(3);
      chk("rst_busy", longint'(busy_w), 0);
      chk("rst_valid", longint'(valid_w), 0);
      chk("rst_result", longint'(res_w), 0);
      chk("rst_ovf", longint'(ovf_w), 0);
      #1 rst_n = 1'b1;
      ro_mode = 1;
      ro_per = 10;
      cycles(12);

      // Period 10 over 100 cycles.
      go(100);
      chk("t1_busy_c1", longint'(busy_w), 1);
      cycles(100);
      chk("t1_valid_c101", longint'(valid_w), 0);
      chk("t1_busy_c101", longint'(busy_w), 1);
      cycles(1);
      chk("t1_valid_c102", longint'(valid_w), 1);
      chk("t1_result", longint'(res_w), 10);
      chk("t1_ovf", longint'(ovf_w), 0);
      ack();
      chk("t1_valid_after_ack", longint'(valid_w), 0);
      chk("t1_busy_after_ack", longint'(busy_w), 0);

      // Period 4 over 100 cycles: 25 rises, narrow saturates at 15.
      ro_per = 4;
      cycles(8);
      go(100);
      cycles(101);
      chk("t2_result_n", longint'(res_n), 15);
      chk("t2_ovf_n", longint'(ovf_n), 1);
      chk("t2_result_w", longint'(res_w), 25);
      ro_per = 10;
      cycles(20);
      chk("t2_hold_valid", longint'(valid_n), 1);
      chk("t2_hold_result", longint'(res_n), 15);

      // Back-to-back ack+start, 30-cycle window.
      ack_start(30);
      chk("b2b_valid_c1", longint'(valid_w), 0);
      chk("b2b_busy_c1", longint'(busy_w), 1);
      cycles(30);
      chk("b2b_valid_c31", longint'(valid_w), 0);
      cycles(1);
      chk("b2b_valid_c32", longint'(valid_w), 1);
      chk("b2b_result_n", longint'(res_n), 3);
      chk("b2b_ovf_n", longint'(ovf_n), 0);
      ack();
      go(20);
      cycles(21);
      chk("t2b_result_n", longint'(res_n), 2);
      chk("t2b_ovf_n", longint'(ovf_n), 0);
      ack();

      // Zero-length and one-cycle windows.
      go(0);
      chk("z_valid_c1", longint'(valid_w), 0);
      cycles(1);
      chk("z_valid_c2", longint'(valid_w), 1);
      chk("z_result", longint'(res_w), 0);
      ack();
      go(1);
      cycles(2);
      chk("one_valid_c3", longint'(valid_w), 1);
      ack();

      // Start pulse during COUNT is ignored.
      go(50);
      cycles(9);
      start = 1'b1;
      gate_len = 16'd5;
      cycles(1);
      start = 1'b0;
      cycles(40);
      chk("ign_valid_c51", longint'(valid_w), 0);
      cycles(1);
      chk("ign_valid_c52", longint'(valid_w), 1);
      chk("ign_result", longint'(res_w), 5);
      ack();

      // Asynchronous reset mid-COUNT.
      go(200);
      cycles(50);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_busy", longint'(busy_w), 0);
      chk("arst_valid", longint'(valid_w), 0);
      chk("arst_result", longint'(res_w), 0);
      chk("arst_ovf_n", longint'(ovf_n), 0);
      cycles(3);
      #1 rst_n = 1'b1;
      cycles(30);
      chk("post_rst_valid", longint'(valid_w), 0);
      go(10);
      cycles(11);
      chk("post_rst_result", longint'(res_w), 1);
      ack();

      // Random ro_in phase and rate, random windows and handshake timing.
      ro_mode = 2;
      stop_at = cyc + 15000;
      len = pick_len();
      go(len);
      while (cyc < stop_at) begin
         wait_valid(len + 5);
         cycles($urandom_range(0, 4));
         ro_rate = $urandom_range(5, 100);
         len = pick_len();
         if ($urandom_range(0, 2) == 0) begin
            ack_start(len);
         end else begin
            ack();
            cycles($urandom_range(0, 3));
            go(len);
         end
      end
      wait_valid(len + 5);
      ack();

      // Maximum-length window.
      ro_rate = 50;
      go(65535);
      wait_valid(65540);
      ack();
      cycles(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
